// File: rtl/sdram_frame_reader.sv
// Avalon-MM burst read master: fetches one frame from the HPS f2h_sdram port
// and streams it out through a first-word-fall-through FIFO.
module sdram_frame_reader #(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 64,
  parameter int BURST_W    = 8,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 24
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  frame_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic [BURST_W-1:0] avm_burstcount,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int SW = AW + 2;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  addr_q;
  logic [BURST_W-1:0] burst_q, len_c;
  logic [CNT_W-1:0]   remaining, frame_len, pop_idx, len_src;
  logic [OW-1:0]      fifo_count, outstanding;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic               done_q, accept, push, pop, credit_ok;
  logic               start_frame, start_empty, last_burst;

  assign start_frame = (state == IDLE) && start && (frame_words != '0);
  assign start_empty = (state == IDLE) && start && (frame_words == '0);

  // Credit is always free at frame start, so the first burst is loaded straight from IDLE.
  assign len_src    = (state == IDLE) ? frame_words : remaining;
  assign len_c      = (len_src >= CNT_W'(BURST_LEN)) ? BURST_W'(BURST_LEN) : len_src[BURST_W-1:0];
  assign credit_ok  = (SW'(fifo_count) + SW'(outstanding) + SW'(len_c)) <= SW'(FIFO_DEPTH);
  assign accept     = (state == HOLD) && !avm_waitrequest;
  assign last_burst = (remaining == CNT_W'(burst_q));
  assign push       = avm_readdatavalid && (outstanding != '0);
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clk100) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_frame) state_next = HOLD;
      REQ:     if (credit_ok) state_next = HOLD;
      HOLD:    if (accept) state_next = last_burst ? DRAIN : REQ;
      DRAIN:   if (pop && out_eof) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    avm_read       = (state == HOLD);
    avm_address    = addr_q;
    avm_burstcount = burst_q;
    done           = done_q;
    out_valid      = (fifo_count != '0);
    out_data       = out_valid ? mem[rd_ptr] : '0;
    out_sof        = out_valid && (pop_idx == '0);
    out_eof        = out_valid && (pop_idx == frame_len - CNT_W'(1));
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      addr_q      <= '0;
      burst_q     <= '0;
      remaining   <= '0;
      frame_len   <= '0;
      pop_idx     <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= start_empty || (pop && out_eof);
      if (start_frame) begin
        addr_q    <= base_addr;
        remaining <= frame_words;
        frame_len <= frame_words;
        burst_q   <= len_c;
        pop_idx   <= '0;
      end else if ((state == REQ) && credit_ok) begin
        burst_q <= len_c;
      end else if (accept) begin
        addr_q    <= addr_q + ADDR_W'(burst_q);
        remaining <= remaining - CNT_W'(burst_q);
      end
      if (pop) begin
        pop_idx <= pop_idx + CNT_W'(1);
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      // Accept and return in the same cycle net out against each other.
      outstanding <= outstanding + (accept ? OW'(burst_q) : '0) - (push ? OW'(1) : '0);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + OW'(1);
        2'b01:   fifo_count <= fifo_count - OW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk100) begin
    if (push) mem[wr_ptr] <= avm_readdata;
  end

  fifo_no_overflow: assert property (@(posedge clk100) disable iff (reset)
    push |-> (fifo_count != OW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Scoreboard bench for sdram_frame_reader with a randomized Avalon slave model.
module tb_sdram_frame_reader;

  localparam int ADDR_W = 29, DATA_W = 64, BURST_W = 8;
  localparam int BURST_LEN = 16, FIFO_DEPTH = 64, CNT_W = 24;

  logic clk100 = 1'b0;
  logic reset, start, busy, done, avm_read, avm_waitrequest, avm_readdatavalid;
  logic out_valid, out_ready, out_sof, out_eof;
  logic [ADDR_W-1:0]  base_addr, avm_address;
  logic [CNT_W-1:0]   frame_words;
  logic [BURST_W-1:0] avm_burstcount;
  logic [DATA_W-1:0]  avm_readdata, out_data;

  sdram_frame_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
    .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk100(clk100), .reset(reset), .start(start), .base_addr(base_addr),
    .frame_words(frame_words), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof)
  );

  always #5 clk100 = ~clk100;

  typedef struct { logic [63:0] data; logic sof; logic eof; } word_t;
  typedef struct { logic [28:0] addr; logic [7:0] count; } burst_t;

  word_t  exp_words[$];
  burst_t exp_bursts[$];
  logic [28:0] ret_q[$];

  int checks = 0, errors = 0;
  int issued = 0, popped = 0, max_inflight = 0;
  int done_pulses = 0, bursts_seen = 0, stall_cycles = 0;
  int wait_budget = 0, ready_mode = 1;
  bit rand_wait = 0, rand_gap = 0, done_due = 0, prev_stall = 0;
  logic [28:0] prev_addr;
  logic [7:0]  prev_count;

  // Slave memory content is a fixed function of the word address.
  function automatic logic [63:0] data_of(input logic [28:0] a);
    return {3'b000, a, 3'b000, ~a};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: the frame's word list and burst split by plain arithmetic.
  task automatic applyStimulus(input logic [28:0] b, input logic [23:0] n);
    int rem;
    int len;
    logic [28:0] a;
    rem = int'(n);
    a = b;
    for (int i = 0; i < int'(n); i++)
      exp_words.push_back('{data_of(b + 29'(i)), i == 0, i == int'(n) - 1});
    while (rem > 0) begin
      len = (rem > BURST_LEN) ? BURST_LEN : rem;
      exp_bursts.push_back('{a, 8'(len)});
      a += 29'(len);
      rem -= len;
    end
    base_addr = b;
    frame_words = n;
    start = 1'b1;
    @(posedge clk100); #1;
    start = 1'b0;
  endtask

  task automatic stray_start(input logic [28:0] b, input logic [23:0] n);
    base_addr = b;
    frame_words = n;
    start = 1'b1;
    @(posedge clk100); #1;
    start = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk100); #1;
    reset = 1'b0;
    exp_words.delete();
    exp_bursts.delete();
    issued = 0;
    popped = 0;
    done_due = 0;
    wait_budget = 0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (done_pulses < target && c < budget) begin
      @(posedge clk100); #1;
      c++;
    end
    checkOutput(name, 64'(done_pulses), 64'(target));
    checkOutput({name, "_words_left"}, 64'(exp_words.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string p);
    checkOutput({p, "_busy"}, 64'(busy), 64'd0);
    checkOutput({p, "_done"}, 64'(done), 64'd0);
    checkOutput({p, "_read"}, 64'(avm_read), 64'd0);
    checkOutput({p, "_address"}, 64'(avm_address), 64'd0);
    checkOutput({p, "_burstcount"}, 64'(avm_burstcount), 64'd0);
    checkOutput({p, "_out_flags"}, 64'({out_valid, out_sof, out_eof}), 64'd0);
    checkOutput({p, "_out_data"}, out_data, 64'd0);
  endtask

  // Avalon slave: accepts bursts, returns words in order with optional gaps and stalls.
  initial begin
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(negedge clk100);
      if (reset) begin
        ret_q.delete();
      end else begin
        if (avm_read && !avm_waitrequest)
          for (int i = 0; i < int'(avm_burstcount); i++) ret_q.push_back(avm_address + 29'(i));
        if (avm_read && avm_waitrequest && wait_budget > 0) wait_budget--;
      end
      @(posedge clk100); #1;
      avm_waitrequest = (wait_budget > 0) || (rand_wait && $urandom_range(0, 3) == 0);
      if (ret_q.size() > 0 && !(rand_gap && $urandom_range(0, 2) == 0)) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = data_of(ret_q.pop_front());
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = {$urandom, $urandom};
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk100); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: bursts, hold stability, stream words, done timing, in-flight words.
  initial begin
    word_t  w;
    burst_t b;
    forever begin
      @(negedge clk100);
      if (reset) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall && avm_read) begin
        checkOutput("hold_address", 64'(avm_address), 64'(prev_addr));
        checkOutput("hold_burstcount", 64'(avm_burstcount), 64'(prev_count));
      end
      prev_stall = avm_read && avm_waitrequest;
      prev_addr = avm_address;
      prev_count = avm_burstcount;
      if (avm_read && avm_waitrequest) stall_cycles++;
      if (avm_read && !avm_waitrequest) begin
        bursts_seen++;
        issued += int'(avm_burstcount);
        if (exp_bursts.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_burst: got addr 0x%0h count %0d, expected none", avm_address, avm_burstcount);
        end else begin
          b = exp_bursts.pop_front();
          checkOutput("burst_address", 64'(avm_address), 64'(b.addr));
          checkOutput("burst_count", 64'(avm_burstcount), 64'(b.count));
        end
      end
      if (done_due) begin
        checkOutput("done_after_eof", 64'({done, busy}), 64'b10);
        done_due = 0;
      end
      if (done) done_pulses++;
      if (out_valid && out_ready) begin
        popped++;
        if (exp_words.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected none", out_data);
        end else begin
          w = exp_words.pop_front();
          checkOutput("word_data", out_data, w.data);
          checkOutput("word_sof", 64'(out_sof), 64'(w.sof));
          checkOutput("word_eof", 64'(out_eof), 64'(w.eof));
        end
        if (out_eof) done_due = 1;
      end
      if (issued - popped > max_inflight) max_inflight = issued - popped;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int d, bs, n;
    logic [28:0] b;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    frame_words = '0;
    repeat (3) @(posedge clk100);
    #1;
    reset = 1'b0;
    check_reset_values("reset");

    $display("[TB] 40-word frame, zero-wait slave");
    d = done_pulses; bs = bursts_seen;
    applyStimulus(29'h1000, 24'd40);
    checkOutput("A_busy_t1", 64'(busy), 64'd1);
    checkOutput("A_read_t1", 64'(avm_read), 64'd1);
    wait_done(d + 1, 500, "A_done");
    checkOutput("A_bursts", 64'(bursts_seen - bs), 64'd3);

    $display("[TB] 5-cycle waitrequest on first burst");
    wait_budget = 5;
    @(posedge clk100); #1;
    stall_cycles = 0;
    d = done_pulses; bs = bursts_seen;
    applyStimulus(29'h2000, 24'd40);
    checkOutput("B_read_t1", 64'(avm_read), 64'd1);
    wait_done(d + 1, 500, "B_done");
    checkOutput("B_stalls", 64'(stall_cycles), 64'd5);
    checkOutput("B_bursts", 64'(bursts_seen - bs), 64'd3);

    $display("[TB] 200-word frame with stream stalled");
    ready_mode = 0;
    d = done_pulses;
    applyStimulus(29'h8000, 24'd200);
    repeat (150) @(posedge clk100);
    #1;
    checkOutput("C_inflight_full", 64'(issued - popped), 64'(FIFO_DEPTH));
    checkOutput("C_read_stalled", 64'(avm_read), 64'd0);
    checkOutput("C_out_valid", 64'(out_valid), 64'd1);
    ready_mode = 1;
    wait_done(d + 1, 2000, "C_done");

    $display("[TB] 1-word frame");
    d = done_pulses; bs = bursts_seen;
    applyStimulus(29'h4000, 24'd1);
    checkOutput("D_burstcount_t1", 64'(avm_burstcount), 64'd1);
    wait_done(d + 1, 100, "D_done");
    checkOutput("D_bursts", 64'(bursts_seen - bs), 64'd1);

    $display("[TB] 0-word frame");
    d = done_pulses; bs = bursts_seen;
    applyStimulus(29'h5000, 24'd0);
    checkOutput("E_done_t1", 64'({done, busy, avm_read}), 64'b100);
    repeat (5) @(posedge clk100);
    #1;
    checkOutput("E_pulses", 64'(done_pulses - d), 64'd1);
    checkOutput("E_bursts", 64'(bursts_seen - bs), 64'd0);

    $display("[TB] start ignored while busy");
    ready_mode = 2; rand_gap = 1;
    d = done_pulses;
    applyStimulus(29'h6000, 24'd48);
    repeat (10) @(posedge clk100);
    #1;
    stray_start(29'h7000, 24'd5);
    checkOutput("F_busy_kept", 64'(busy), 64'd1);
    wait_done(d + 1, 2000, "F_done");
    repeat (5) @(posedge clk100);
    #1;
    checkOutput("F_pulses", 64'(done_pulses - d), 64'd1);
    checkOutput("F_idle", 64'(busy), 64'd0);

    $display("[TB] reset mid-burst then fresh frame");
    ready_mode = 1; rand_gap = 0;
    applyStimulus(29'h1234, 24'd40);
    repeat (6) @(posedge clk100);
    #1;
    apply_reset();
    check_reset_values("G_after_reset");
    d = done_pulses;
    applyStimulus(29'h3000, 24'd16);
    wait_done(d + 1, 500, "G_done");

    $display("[TB] randomized frames");
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(1, 120);
      b = 29'($urandom_range(0, 24'hFFFFFF));
      ready_mode = 2;
      rand_gap = 1'($urandom_range(0, 1));
      rand_wait = 1'($urandom_range(0, 1));
      d = done_pulses;
      applyStimulus(b, 24'(n));
      wait_done(d + 1, 4000, "R_done");
    end
    rand_gap = 0; rand_wait = 0; ready_mode = 1;

    checkOutput("max_inflight_within_depth", 64'(max_inflight <= FIFO_DEPTH), 64'd1);
    checkOutput("bursts_left", 64'(exp_bursts.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
